// File: rtl/img_win_ctrl_pkg.sv
// Shared types and default geometry for the image window scan controller.
// The state enum is here so the controller and any observers agree on encoding.
package img_win_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FILL,
        ST_LOAD,
        ST_WIN,
        ST_DONE
    } state_t;

    localparam int DEF_IMG_H  = 8;
    localparam int DEF_IMG_W  = 8;
    localparam int DEF_K_H    = 3;
    localparam int DEF_K_W    = 3;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/img_win_ctrl.sv
// Stride-1 raster window scanner: issues K_H-pixel column reads to the image buffer
// and shifts the returned columns into a K_H x K_W window register presented downstream.
module img_win_ctrl
    import img_win_ctrl_pkg::*;
#(
    parameter int IMG_H  = DEF_IMG_H,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int K_H    = DEF_K_H,
    parameter int K_W    = DEF_K_W,
    parameter int ROW_W  = $clog2(IMG_H),
    parameter int COL_W  = $clog2(IMG_W),
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [ROW_W-1:0]            rd_row,
    output logic [COL_W-1:0]            rd_col,
    output logic                        load_en,
    output logic                        clear,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [ROW_W-1:0]            win_row,
    output logic [COL_W-1:0]            win_col,
    input  logic [K_H*DATA_W-1:0]       rd_data,
    output logic [K_H*K_W*DATA_W-1:0]   win_data
);

    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - K_H);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - K_W);
    localparam logic [COL_W-1:0] LAST_FILL = COL_W'(K_W - 1);
    localparam logic [COL_W-1:0] K_W_C     = COL_W'(K_W);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_col;
    logic [COL_W-1:0]      r_fill;
    logic                  r_load_en;
    logic                  w_hs;
    logic [K_H*DATA_W-1:0] r_win [K_W];

    assign w_hs    = (r_state == ST_WIN) && win_ready;
    assign load_en = r_load_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are decoded from state; a WIN handshake that still has columns to
    // the right fetches the next column in the same cycle to keep a 2-cycle window period.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        rd_en       = 1'b0;
        rd_row      = '0;
        rd_col      = '0;
        clear       = 1'b0;
        win_valid   = 1'b0;
        win_row     = '0;
        win_col     = '0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_CLR;
                end
            end
            ST_CLR: begin
                clear       = 1'b1;
                w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                rd_en  = 1'b1;
                rd_row = r_row;
                rd_col = r_fill;
                if (r_fill == LAST_FILL) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_WIN;
            end
            ST_WIN: begin
                win_valid = 1'b1;
                win_row   = r_row;
                win_col   = r_col;
                if (win_ready) begin
                    if (r_col != LAST_COL) begin
                        rd_en       = 1'b1;
                        rd_row      = r_row;
                        rd_col      = r_col + K_W_C;
                        w_state_nxt = ST_LOAD;
                    end else if (r_row != LAST_ROW) begin
                        w_state_nxt = ST_CLR;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row     <= '0;
            r_col     <= '0;
            r_fill    <= '0;
            r_load_en <= 1'b0;
        end else begin
            r_load_en <= rd_en;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_row <= '0;
                        r_col <= '0;
                    end
                end
                ST_CLR: begin
                    r_col  <= '0;
                    r_fill <= '0;
                end
                ST_FILL: begin
                    if (r_fill != LAST_FILL) begin
                        r_fill <= r_fill + COL_W'(1);
                    end
                end
                ST_WIN: begin
                    if (w_hs) begin
                        if (r_col != LAST_COL) begin
                            r_col <= r_col + COL_W'(1);
                        end else if (r_row != LAST_ROW) begin
                            r_row <= r_row + ROW_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Window register: column 0 is the leftmost (oldest) column, new columns enter at K_W-1.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int j = 0; j < K_W; j++) begin
                r_win[j] <= '0;
            end
        end else if (r_load_en) begin
            for (int j = 0; j < K_W - 1; j++) begin
                r_win[j] <= r_win[j+1];
            end
            r_win[K_W-1] <= rd_data;
        end
    end

    for (genvar j = 0; j < K_W; j++) begin : g_win
        assign win_data[j*K_H*DATA_W +: K_H*DATA_W] = r_win[j];
    end

endmodule

// File: doc/img_win_ctrl.md
IMG_WIN_CTRL -- requirements
Module: img_win_ctrl

Interface
REQ-001 SHALL have parameters: IMG_H, 8, image rows; IMG_W, 8, image columns; K_H, 3, window rows; K_W, 3, window columns; ROW_W, $clog2(IMG_H); COL_W, $clog2(IMG_W).
REQ-002 SHALL have ports: clk  in  1  clock.
REQ-003 rst_n  in  1  reset; one clock, synchronous, active-low.
REQ-004 start  in  1  begin full-image scan; sampled only in IDLE.
REQ-005 busy  out  1  high in every state except IDLE.
REQ-006 done  out  1  one-cycle pulse at scan end.
REQ-007 rd_en  out  1  column read request to image buffer; data returns next cycle.
REQ-008 rd_row  out  ROW_W  top row of the K_H-pixel column read.
REQ-009 rd_col  out  COL_W  column index of the read.
REQ-010 load_en  out  1  shift enable to window register (rd_en delayed one cycle).
REQ-011 clear  out  1  zero window register.
REQ-012 win_valid  out  1  complete K_H x K_W window present.
REQ-013 win_ready  in  1  downstream PE accepts window.
REQ-014 win_row / win_col  out  ROW_W / COL_W  top-left position of presented window.

Function
REQ-015 SHALL scan windows at stride 1, raster order: bands r=0..IMG_H-K_H, columns c=0..IMG_W-K_W.
REQ-016 States: IDLE, CLR, FILL, LOAD, WIN, DONE.
REQ-017 IDLE: start=1 -> CLR; otherwise stay; start while busy ignored.
REQ-018 CLR: clear=1 for exactly one cycle, col counter=0 -> FILL.
REQ-019 FILL: rd_en=1 for K_W consecutive cycles, rd_row=r, rd_col=0..K_W-1 -> LOAD after last read.
REQ-020 load_en SHALL equal rd_en of previous cycle, in every state.
REQ-021 LOAD: one cycle (final load_en) -> WIN.
REQ-022 WIN: win_valid=1, win_row=r, win_col=c; held stable until win_valid&&win_ready.
REQ-023 On handshake with c<IMG_W-K_W: rd_en=1 same cycle, rd_col=c+K_W, rd_row=r, c++ -> LOAD (window period 2 cycles when always ready).
REQ-024 On handshake with c=IMG_W-K_W and r<IMG_H-K_H: r++ -> CLR, no read.
REQ-025 On handshake with last window: -> DONE; DONE asserts done=1 one cycle -> IDLE.
REQ-026 win_valid SHALL be 0 outside WIN; rd_en 0 outside FILL and WIN-handshake cycle.
REQ-027 No read SHALL issue while win_valid && !win_ready (stall holds all outputs).
REQ-028 Counters SHALL not wrap; r, c reset to 0 on entering CLR from IDLE.
REQ-029 IMG_H=K_H and/or IMG_W=K_W SHALL yield exactly one band / one window per band.

Reset
REQ-030 rst_n=0 at clk edge SHALL force IDLE, all outputs 0, counters 0, including mid-scan; no done pulse.
REQ-031 rst_n has priority over start and win_ready.

Structure
REQ-032 Shared package SHALL hold state enum type and default IMG_H/IMG_W/K_H/K_W constants.
REQ-033 No sub-module; counters and FSM inline; window register instantiated beside it at top level, driven by load_en/clear, image buffer data routed directly to it.

Verification
REQ-034 5x5 image, K=3, win_ready=1, start at cycle 0 -> CLR cycle 1, reads cols 0,1,2 cycles 2-4, first win_valid cycle 6 (0,0), nine windows total, done pulse cycle 31, busy low cycle 32.
REQ-035 win_ready=0 for 4 cycles at window (1,1) -> win_valid, win_row=1, win_col=1 held, rd_en=0 throughout, resumes next window after handshake.
REQ-036 rst_n=0 during FILL of band 1 -> next cycle IDLE, all outputs 0; subsequent start rescans from (0,0).
REQ-037 start pulses while busy -> ignored, window count and done timing unchanged.
REQ-038 IMG_H=3, IMG_W=3 -> single window (0,0), one CLR, three reads, done once.
REQ-039 Every cycle: load_en == previous rd_en; clear only in CLR; rd_col never exceeds IMG_W-1.
